// File: rtl/autoscale_sched_pkg.sv
// Shared definitions for the autoscale update scheduler: FSM state
// encoding and the default acknowledge timeout.
package autoscale_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SELECT = 2'd2,
        ST_ACK    = 2'd3
    } sched_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit priority encoder: returns the index of the
// lowest set request bit and a valid flag when any bit is set.
module lsb_priority_encoder #(
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = 2
) (
    input  logic [CHANNELS-1:0] req,
    output logic [CH_BITS-1:0]  index,
    output logic                valid
);

    // Scan upward; the first set bit found is kept.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (req[i] && !valid) begin
                index = CH_BITS'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/autoscale_update_scheduler.sv
// Periodic round-robin update scheduler for autoscale controllers. Each
// round latches a channel mask, issues a one-cycle UPDATE to each selected
// channel in ascending order and waits for its acknowledge or a timeout.
module autoscale_update_scheduler
    import autoscale_sched_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int CH_BITS        = 2,
    parameter int PERIOD_BITS    = 16,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   CE,
    input  logic                   ENABLE,
    input  logic [PERIOD_BITS-1:0] PERIOD,
    input  logic [CHANNELS-1:0]    CH_MASK,
    input  logic                   CLEAR_ERR,
    input  logic [CHANNELS-1:0]    DELAY_UPDATED,
    output logic [CHANNELS-1:0]    UPDATE,
    output logic [CH_BITS-1:0]     CUR_CH,
    output logic                   BUSY,
    output logic                   ROUND_DONE,
    output logic [CHANNELS-1:0]    TIMEOUT_ERR
);

    localparam int TO_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    sched_state_e            state;
    logic [PERIOD_BITS-1:0]  period_cnt;
    logic [TO_BITS-1:0]      timeout_cnt;
    logic [CHANNELS-1:0]     pending;
    logic [CH_BITS-1:0]      sel_idx;
    logic                    sel_valid;
    logic [CHANNELS-1:0]     sel_onehot;

    lsb_priority_encoder #(
        .CHANNELS (CHANNELS),
        .CH_BITS  (CH_BITS)
    ) u_select (
        .req   (pending),
        .index (sel_idx),
        .valid (sel_valid)
    );

    assign sel_onehot = CHANNELS'(1) << sel_idx;

    // Scheduler FSM with registered outputs; everything advances only on CE.
    // A timeout in the same cycle as CLEAR_ERR re-sets its bit because the
    // later assignment wins.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            period_cnt  <= '0;
            timeout_cnt <= '0;
            pending     <= '0;
            UPDATE      <= '0;
            CUR_CH      <= '0;
            BUSY        <= 1'b0;
            ROUND_DONE  <= 1'b0;
            TIMEOUT_ERR <= '0;
        end else if (CE) begin
            UPDATE     <= '0;
            ROUND_DONE <= 1'b0;
            if (CLEAR_ERR) begin
                TIMEOUT_ERR <= '0;
            end
            case (state)
                ST_IDLE: begin
                    if (ENABLE) begin
                        period_cnt <= PERIOD;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (period_cnt != '0) begin
                        period_cnt <= period_cnt - 1'b1;
                    end else begin
                        pending <= CH_MASK;
                        BUSY    <= 1'b1;
                        state   <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (sel_valid) begin
                        if (ENABLE) begin
                            CUR_CH      <= sel_idx;
                            UPDATE      <= sel_onehot;
                            pending     <= pending & ~sel_onehot;
                            timeout_cnt <= TO_BITS'(TIMEOUT_CYCLES);
                            state       <= ST_ACK;
                        end else begin
                            // Disabled mid-round: drop what is left, no ROUND_DONE.
                            pending <= '0;
                            BUSY    <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end else begin
                        ROUND_DONE <= 1'b1;
                        BUSY       <= 1'b0;
                        if (ENABLE) begin
                            period_cnt <= PERIOD;
                            state      <= ST_WAIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ACK: begin
                    if (DELAY_UPDATED[CUR_CH]) begin
                        state <= ST_SELECT;
                    end else if (timeout_cnt == '0) begin
                        TIMEOUT_ERR[CUR_CH] <= 1'b1;
                        state               <= ST_SELECT;
                    end else begin
                        timeout_cnt <= timeout_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
